// File: rtl/lanes_serializer.sv
// Two-lane LSB-first serializer paced by a ready/valid handshake. The symbol length
// (8, 132 or 66 bits) is latched from gen_speed at each load and held for the whole symbol.
module lanes_serializer #(
  parameter int WIDTH = 132
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_ser,
  input  logic [1:0]       gen_speed,
  input  logic [WIDTH-1:0] lane_0_tx_parallel,
  input  logic [WIDTH-1:0] lane_1_tx_parallel,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             lane_0_tx_ser,
  output logic             lane_1_tx_ser,
  output logic             sym_start,
  output logic             underflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {
    GEN4     = 2'b00,
    GEN3     = 2'b01,
    GEN2     = 2'b10,
    GEN_RSVD = 2'b11
  } gen_t;

  state_t           state;
  gen_t             gen_q;
  gen_t             gen_new;
  logic [CW-1:0]    count;
  logic [CW-1:0]    last_q;
  logic [WIDTH-1:0] shift_0;
  logic [WIDTH-1:0] shift_1;
  logic [WIDTH-1:0] load_mask;

  // Index of the final bit of a symbol; the reserved encoding behaves as Gen4.
  function automatic logic [CW-1:0] last_bit(input gen_t g);
    case (g)
      GEN3:    last_bit = CW'(WIDTH - 1);
      GEN2:    last_bit = CW'(65);
      default: last_bit = CW'(7);
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] width_mask(input gen_t g);
    case (g)
      GEN3:    width_mask = '1;
      GEN2:    width_mask = WIDTH'({66{1'b1}});
      default: width_mask = WIDTH'({8{1'b1}});
    endcase
  endfunction

  assign gen_new   = gen_t'(gen_speed);
  assign load_mask = width_mask(gen_new);
  assign last_q    = last_bit(gen_q);

  // Pure register decode, so the upstream encoder may build tx_valid from tx_ready.
  assign tx_ready = (state == RUN) && (count == last_q);

  // NOTE: every register here uses <= so all right-hand sides see pre-edge values;
  // the load path reads tx_ready and the shift registers in the same edge it updates them.
  always_ff @(posedge clk) begin
    if (rst || !enable_ser) begin
      state         <= IDLE;
      gen_q         <= GEN4;
      count         <= '0;
      shift_0       <= '0;
      shift_1       <= '0;
      lane_0_tx_ser <= 1'b0;
      lane_1_tx_ser <= 1'b0;
      sym_start     <= 1'b0;
      underflow     <= 1'b0;
    end else if (state == IDLE) begin
      // Park the counter on the last slot so the first RUN cycle is a load slot.
      state         <= RUN;
      count         <= last_q;
      lane_0_tx_ser <= 1'b0;
      lane_1_tx_ser <= 1'b0;
      sym_start     <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      lane_0_tx_ser <= shift_0[0];
      lane_1_tx_ser <= shift_1[0];
      // count==0 means bit 0 of the freshly loaded word is being sent this edge.
      sym_start     <= (count == '0);
      if (tx_ready) begin
        gen_q     <= gen_new;
        count     <= '0;
        shift_0   <= tx_valid ? (lane_0_tx_parallel & load_mask) : '0;
        shift_1   <= tx_valid ? (lane_1_tx_parallel & load_mask) : '0;
        underflow <= !tx_valid;
      end else begin
        count     <= count + 1'b1;
        shift_0   <= shift_0 >> 1;
        shift_1   <= shift_1 >> 1;
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lanes_serializer.sv
// Bench for lanes_serializer: per-cycle scoreboard of serial bits, sym_start, underflow
// and tx_ready, plus a Gen4 vector table and hand sequences for multi-cycle corners.
module tb_lanes_serializer;

  localparam int W = 132;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable_ser;
  logic [1:0]   gen_speed;
  logic [W-1:0] p0;
  logic [W-1:0] p1;
  logic         tx_valid;
  logic         tx_ready;
  logic         l0;
  logic         l1;
  logic         sym_start;
  logic         underflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lanes_serializer #(.WIDTH(W)) dut (
    .clk                (clk),
    .rst                (rst),
    .enable_ser         (enable_ser),
    .gen_speed          (gen_speed),
    .lane_0_tx_parallel (p0),
    .lane_1_tx_parallel (p1),
    .tx_valid           (tx_valid),
    .tx_ready           (tx_ready),
    .lane_0_tx_ser      (l0),
    .lane_1_tx_ser      (l1),
    .sym_start          (sym_start),
    .underflow          (underflow)
  );

  typedef struct packed {
    logic ss;
    logic b0;
    logic b1;
  } exp_t;

  typedef struct {
    logic [W-1:0] p0;
    logic [W-1:0] p1;
    logic [7:0]   e0;
    logic [7:0]   e1;
  } vec_t;

  exp_t sb[$];

  // Reference model of the handshake timing.
  logic m_run   = 1'b0;
  int   m_cnt   = 0;
  int   m_n     = 8;
  logic m_ready = 1'b0;

  int   cyc            = 0;
  int   last_ready_cyc = 0;
  int   ready_gap      = 0;
  int   uf_seen        = 0;
  logic [W-1:0] h0 = '0;
  logic [W-1:0] h1 = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int n_of(input logic [1:0] g);
    case (g)
      2'b01:   n_of = 132;
      2'b10:   n_of = 66;
      default: n_of = 8;
    endcase
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    rand_word = t[W-1:0];
  endfunction

  // One clock: advance the model, compare every output, push newly loaded bits.
  task automatic tick();
    logic flush;
    logic load;
    exp_t e;
    int   n;
    flush = rst || !enable_ser;
    load  = !flush && m_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (flush) begin
      m_run = 1'b0;
      m_cnt = 0;
      m_n   = 8;
      sb.delete();
    end else if (!m_run) begin
      m_run = 1'b1;
      m_cnt = m_n - 1;
    end else if (load) begin
      m_n   = n_of(gen_speed);
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    check("outputs{sym,uf,l0,l1}", W'({sym_start, underflow, l0, l1}),
          W'({e.ss, load && !tx_valid, e.b0, e.b1}));
    if (load) begin
      n = n_of(gen_speed);
      for (int i = 0; i < n; i++) begin
        e.ss = (i == 0);
        e.b0 = tx_valid & p0[i];
        e.b1 = tx_valid & p1[i];
        sb.push_back(e);
      end
    end
    m_ready = m_run && (m_cnt == m_n - 1);
    check("tx_ready", W'(tx_ready), W'(m_ready));
    h0 = {l0, h0[W-1:1]};
    h1 = {l1, h1[W-1:1]};
    if (underflow) uf_seen++;
    if (tx_ready) begin
      ready_gap      = cyc - last_ready_cyc;
      last_ready_cyc = cyc;
    end
  endtask

  // Wait (bounded) for a load slot, present the word, clock the load edge.
  task automatic send(input logic [1:0] g, input logic [W-1:0] w0, input logic [W-1:0] w1,
                      input logic v);
    int guard;
    guard = 0;
    while (!m_ready && guard < 300) begin
      tick();
      guard++;
    end
    if (!m_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout at cycle %0d: no load slot within 300 cycles", cyc);
      return;
    end
    gen_speed = g;
    p0        = w0;
    p1        = w1;
    tx_valid  = v;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t         vecs[4];
    logic [W-1:0] wa, wb, w1a, w1b, w2a, w2b;
    int           uf0;

    vecs[0].p0 = W'(8'hA5);                      vecs[0].e0 = 8'hA5;
    vecs[0].p1 = W'(8'h3C);                      vecs[0].e1 = 8'h3C;
    vecs[1].p0 = {{124{1'b1}}, 8'h0F};           vecs[1].e0 = 8'h0F;
    vecs[1].p1 = {{124{1'b1}}, 8'hE1};           vecs[1].e1 = 8'hE1;
    vecs[2].p0 = '0;                             vecs[2].e0 = 8'h00;
    vecs[2].p1 = W'(8'hFF);                      vecs[2].e1 = 8'hFF;
    vecs[3].p0 = {4'h0, {30{4'hA}}, 8'h80};      vecs[3].e0 = 8'h80;
    vecs[3].p1 = {4'hF, {30{4'h5}}, 8'h01};      vecs[3].e1 = 8'h01;

    // Reset held with enable and valid high: everything stays quiet.
    rst = 1'b1; enable_ser = 1'b1; tx_valid = 1'b1; gen_speed = 2'b00; p0 = '1; p1 = '1;
    repeat (3) tick();
    check("rst_ready_low", W'(tx_ready), W'(0));
    rst = 1'b0;
    tick();
    check("first_ready_after_rst", W'(tx_ready), W'(1));

    // Gen4 vector table, streamed back to back.
    for (int v = 0; v < 4; v++) begin
      send(2'b00, vecs[v].p0, vecs[v].p1, 1'b1);
      if (v > 0) begin
        check($sformatf("vec%0d_lane0", v - 1), W'(h0[W-1:W-8]), W'(vecs[v-1].e0));
        check($sformatf("vec%0d_lane1", v - 1), W'(h1[W-1:W-8]), W'(vecs[v-1].e1));
        check("gen4_ready_period", W'(ready_gap), W'(8));
      end
    end

    // Gen3 underflow slot followed immediately by a valid word.
    uf0 = uf_seen;
    send(2'b01, rand_word(), rand_word(), 1'b0);
    check("vec3_lane0", W'(h0[W-1:W-8]), W'(vecs[3].e0));
    check("vec3_lane1", W'(h1[W-1:W-8]), W'(vecs[3].e1));
    send(2'b01, rand_word(), rand_word(), 1'b1);
    check("gen3_ready_period", W'(ready_gap), W'(132));
    check("underflow_pulse_count", W'(uf_seen - uf0), W'(1));
    check("underflow_zero_word", h0 | h1, '0);

    // Gen2 words with the unused upper bits set.
    w1a = rand_word(); w1a[W-1:66] = '1;
    w1b = rand_word(); w1b[W-1:66] = '1;
    w2a = rand_word(); w2a[W-1:66] = '1;
    w2b = rand_word(); w2b[W-1:66] = '1;
    send(2'b10, w1a, w1b, 1'b1);
    send(2'b10, w2a, w2b, 1'b1);
    check("gen2_ready_period_a", W'(ready_gap), W'(66));
    check("gen2_word1_lane0", W'(h0[W-1:66]), W'(w1a[65:0]));
    check("gen2_word1_lane1", W'(h1[W-1:66]), W'(w1b[65:0]));
    send(2'b10, rand_word(), rand_word(), 1'b1);
    check("gen2_ready_period_b", W'(ready_gap), W'(66));
    check("gen2_word2_lane0", W'(h0[W-1:66]), W'(w2a[65:0]));
    check("gen2_word2_lane1", W'(h1[W-1:66]), W'(w2b[65:0]));

    // gen_speed moves Gen4 -> Gen2 at count 3: the 8-bit symbol still completes.
    wa = rand_word();
    wb = rand_word();
    send(2'b00, wa, wb, 1'b1);
    repeat (3) tick();
    gen_speed = 2'b10;
    send(2'b10, rand_word(), rand_word(), 1'b1);
    check("gen_change_period_8", W'(ready_gap), W'(8));
    check("gen_change_lane0", W'(h0[W-1:W-8]), W'(wa[7:0]));
    check("gen_change_lane1", W'(h1[W-1:W-8]), W'(wb[7:0]));
    send(2'b10, rand_word(), rand_word(), 1'b1);
    check("gen_change_period_66", W'(ready_gap), W'(66));

    // Gen3 symbol aborted at count 40, re-enabled 5 cycles later.
    send(2'b01, rand_word(), rand_word(), 1'b1);
    repeat (40) tick();
    enable_ser = 1'b0;
    tick();
    check("flush_outputs", W'({sym_start, underflow, l0, l1, tx_ready}), W'(0));
    repeat (4) tick();
    enable_ser = 1'b1;
    tick();
    check("reenable_ready", W'(tx_ready), W'(1));
    wa = rand_word();
    wb = rand_word();
    send(2'b01, wa, wb, 1'b1);
    check("reenable_no_early_start", W'(sym_start), W'(0));
    tick();
    check("reenable_bit0", W'({sym_start, l0, l1}), W'({1'b1, wa[0], wb[0]}));

    enable_ser = 1'b0;
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
